// File: rtl/state_ball_pkg.sv
// Shared definitions for the pong ball engine: FSM states and direction encodings.
package state_ball_pkg;

  // Ball engine game states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_RUN   = 3'd2,
    ST_MISS  = 3'd3,
    ST_OVER  = 3'd4
  } state_t;

  // One-bit direction: positive moves right/down, negative moves left/up
  localparam logic DIR_POS = 1'b0;
  localparam logic DIR_NEG = 1'b1;

  // Width of the lives counter
  localparam int unsigned LIVES_W = 3;

endpackage

// File: rtl/state_ball_tick_gen.sv
// Game tick generator: divides clk into one-cycle ticks every TICK_DIV cycles while running.
module state_ball_tick_gen #(
  parameter int unsigned TICK_DIV = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_run,
  input  logic i_clr,
  output logic o_tick_c
);

  localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] r_cnt;

  // Free-running divider; clr wins over run, and it holds while not running
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_run) begin
      if (r_cnt == CNT_LAST) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  // Gated by run so a divide-by-one counter does not tick while parked
  assign o_tick_c = i_run && (r_cnt == CNT_LAST);

endmodule

// File: rtl/state_ball.sv
// Pong ball engine: moves the ball diagonally per tick, bounces off walls and the paddle,
// and tracks score, lives and game over.
module state_ball
  import state_ball_pkg::*;
#(
  parameter int unsigned BIT_WIDTH  = 2,
  parameter int unsigned ROW_BITS   = 3,
  parameter int unsigned TICK_DIV   = 4,
  parameter int unsigned START_X    = 1,
  parameter int unsigned LIVES      = 3,
  parameter int unsigned MISS_HOLD  = 2,
  parameter int unsigned SCORE_BITS = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_en,
  input  logic [BIT_WIDTH-1:0]  i_state_left,
  input  logic [BIT_WIDTH-1:0]  i_state_right,
  output logic [BIT_WIDTH-1:0]  o_ball_x,
  output logic [ROW_BITS-1:0]   o_ball_y,
  output logic                  o_hit,
  output logic                  o_miss,
  output logic [SCORE_BITS-1:0] o_score,
  output logic [LIVES_W-1:0]    o_lives,
  output logic                  o_game_over
);

  localparam int unsigned COLS   = 2 ** BIT_WIDTH;
  localparam int unsigned ROWS   = 2 ** ROW_BITS;
  localparam int unsigned HOLD_W = (MISS_HOLD > 1) ? $clog2(MISS_HOLD) : 1;

  localparam logic [BIT_WIDTH-1:0]  X_MAX      = BIT_WIDTH'(COLS - 1);
  localparam logic [BIT_WIDTH-1:0]  X_START    = BIT_WIDTH'(START_X);
  localparam logic [ROW_BITS-1:0]   ROW_PAD    = ROW_BITS'(ROWS - 1);
  localparam logic [ROW_BITS-1:0]   ROW_CHK    = ROW_BITS'(ROWS - 2);
  localparam logic [ROW_BITS-1:0]   ROW_BOUNCE = ROW_BITS'(ROWS - 3);
  localparam logic [HOLD_W-1:0]     HOLD_LAST  = HOLD_W'(MISS_HOLD - 1);
  localparam logic [SCORE_BITS-1:0] SCORE_MAX  = {SCORE_BITS{1'b1}};
  localparam logic [LIVES_W-1:0]    LIVES_INIT = LIVES_W'(LIVES);

  state_t                r_state;
  logic [BIT_WIDTH-1:0]  r_x;
  logic [ROW_BITS-1:0]   r_y;
  logic                  r_dx;
  logic                  r_dy;
  logic                  r_hit;
  logic                  r_miss;
  logic [SCORE_BITS-1:0] r_score;
  logic [LIVES_W-1:0]    r_lives;
  logic                  r_game_over;
  logic [HOLD_W-1:0]     r_hold;

  logic                  w_tick;
  logic                  w_run;
  logic                  w_clr;
  logic [BIT_WIDTH-1:0]  w_x_next;
  logic                  w_dx_next;
  logic                  w_on_paddle;

  // Counter only advances while the ball is in play. Every non-tick state change
  // is caused by en dropping, so clearing on !en plus the natural wrap on tick
  // edges keeps the counter at zero on each state entry.
  assign w_run = (r_state == ST_SERVE) || (r_state == ST_RUN) || (r_state == ST_MISS);
  assign w_clr = ~i_en;

  state_ball_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_run    (w_run),
    .i_clr    (w_clr),
    .o_tick_c (w_tick)
  );

  // Horizontal step: reflect at either side wall, then move one cell in the new direction
  always_comb begin
    w_dx_next = r_dx;
    if (((r_dx == DIR_POS) && (r_x == X_MAX)) || ((r_dx == DIR_NEG) && (r_x == '0))) begin
      w_dx_next = ~r_dx;
    end
    w_x_next = (w_dx_next == DIR_POS) ? (r_x + BIT_WIDTH'(1)) : (r_x - BIT_WIDTH'(1));
  end

  // Paddle span test on the pre-move column; an inverted span can never match
  assign w_on_paddle = (i_state_left <= r_x) && (r_x <= i_state_right);

  // Game FSM with ball position, direction, strobes and counters
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_x         <= X_START;
      r_y         <= '0;
      r_dx        <= DIR_POS;
      r_dy        <= DIR_POS;
      r_hit       <= 1'b0;
      r_miss      <= 1'b0;
      r_score     <= '0;
      r_lives     <= LIVES_INIT;
      r_game_over <= 1'b0;
      r_hold      <= '0;
    end else begin
      r_hit  <= 1'b0;
      r_miss <= 1'b0;
      if (!i_en && (r_state != ST_OVER)) begin
        r_state <= ST_IDLE;
        r_x     <= X_START;
        r_y     <= '0;
        r_dx    <= DIR_POS;
        r_dy    <= DIR_POS;
        r_hold  <= '0;
      end else begin
        unique case (r_state)
          ST_IDLE: begin
            r_state <= ST_SERVE;
          end
          ST_SERVE: begin
            if (w_tick) begin
              r_state <= ST_RUN;
            end
          end
          ST_RUN: begin
            if (w_tick) begin
              r_x  <= w_x_next;
              r_dx <= w_dx_next;
              if ((r_dy == DIR_NEG) && (r_y == '0)) begin
                r_dy <= DIR_POS;
                r_y  <= ROW_BITS'(1);
              end else if ((r_dy == DIR_POS) && (r_y == ROW_CHK)) begin
                if (w_on_paddle) begin
                  r_dy  <= DIR_NEG;
                  r_y   <= ROW_BOUNCE;
                  r_hit <= 1'b1;
                  if (r_score != SCORE_MAX) begin
                    r_score <= r_score + SCORE_BITS'(1);
                  end
                end else begin
                  r_y     <= ROW_PAD;
                  r_miss  <= 1'b1;
                  r_lives <= r_lives - LIVES_W'(1);
                  r_hold  <= '0;
                  r_state <= ST_MISS;
                end
              end else begin
                r_y <= (r_dy == DIR_POS) ? (r_y + ROW_BITS'(1)) : (r_y - ROW_BITS'(1));
              end
            end
          end
          ST_MISS: begin
            if (w_tick) begin
              if (r_hold == HOLD_LAST) begin
                r_hold <= '0;
                if (r_lives != '0) begin
                  r_state <= ST_SERVE;
                  r_x     <= X_START;
                  r_y     <= '0;
                  r_dx    <= DIR_POS;
                  r_dy    <= DIR_POS;
                end else begin
                  r_state     <= ST_OVER;
                  r_game_over <= 1'b1;
                end
              end else begin
                r_hold <= r_hold + HOLD_W'(1);
              end
            end
          end
          ST_OVER: begin
            r_state <= ST_OVER;
          end
          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign o_ball_x    = r_x;
  assign o_ball_y    = r_y;
  assign o_hit       = r_hit;
  assign o_miss      = r_miss;
  assign o_score     = r_score;
  assign o_lives     = r_lives;
  assign o_game_over = r_game_over;

endmodule

// File: tb/tb_state_ball.sv
// Scoreboard bench for state_ball: driver queues hand-computed expectations, monitor checks them.
module tb_state_ball;

  typedef struct {
    int sel;
    int chk_pos;
    int x;
    int y;
    int hit;
    int miss;
    int score;
    int lives;
    int go;
    int step;
  } exp_t;

  exp_t q[$];
  exp_t m_e;
  int   checks  = 0;
  int   errors  = 0;
  int   step_no = 0;
  int   ax, ay, ahit, amiss, ascore, alives, ago;

  logic       clk   = 1'b0;
  logic       rst   = 1'b1;
  logic       en    = 1'b0;
  logic [1:0] left  = 2'd1;
  logic [1:0] right = 2'd2;

  always #5 clk = ~clk;

  // Default build, TICK_DIV = 1
  logic [1:0] x0;  logic [2:0] y0;  logic hit0, miss0, go0;  logic [3:0] sc0;  logic [2:0] lv0;
  // TICK_DIV = 4
  logic [1:0] x1;  logic [2:0] y1;  logic hit1, miss1, go1;  logic [3:0] sc1;  logic [2:0] lv1;
  // TICK_DIV = 1, SCORE_BITS = 2
  logic [1:0] x2;  logic [2:0] y2;  logic hit2, miss2, go2;  logic [1:0] sc2;  logic [2:0] lv2;

  state_ball #(.TICK_DIV(1)) dut0 (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_state_left(left), .i_state_right(right),
    .o_ball_x(x0), .o_ball_y(y0), .o_hit(hit0), .o_miss(miss0), .o_score(sc0),
    .o_lives(lv0), .o_game_over(go0)
  );

  state_ball #(.TICK_DIV(4)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_state_left(left), .i_state_right(right),
    .o_ball_x(x1), .o_ball_y(y1), .o_hit(hit1), .o_miss(miss1), .o_score(sc1),
    .o_lives(lv1), .o_game_over(go1)
  );

  state_ball #(.TICK_DIV(1), .SCORE_BITS(2)) dut2 (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_state_left(left), .i_state_right(right),
    .o_ball_x(x2), .o_ball_y(y2), .o_hit(hit2), .o_miss(miss2), .o_score(sc2),
    .o_lives(lv2), .o_game_over(go2)
  );

  function automatic exp_t mk(int sel, int chk_pos, int x, int y, int hit, int miss,
                              int score, int lives, int go);
    exp_t e;
    e.sel = sel; e.chk_pos = chk_pos; e.x = x; e.y = y; e.hit = hit; e.miss = miss;
    e.score = score; e.lives = lives; e.go = go; e.step = 0;
    return e;
  endfunction

  // Apply inputs just after an edge, then queue the outputs expected after the next edge
  task automatic drive(input int r, input int e, input int l, input int rr, input exp_t ex);
    #1;
    rst   = 1'(r);
    en    = 1'(e);
    left  = 2'(l);
    right = 2'(rr);
    @(posedge clk);
    ex.step = step_no;
    step_no++;
    q.push_back(ex);
  endtask

  task automatic cmp(input string nm, input int st, input int act, input int ex);
    checks++;
    if (act != ex) begin
      errors++;
      $display("FAIL %s step %0d: got %0d expected %0d", nm, st, act, ex);
    end
  endtask

  // Monitor: one queued expectation per clock, sampled mid-cycle
  always @(negedge clk) begin
    if (q.size() > 0) begin
      m_e = q.pop_front();
      case (m_e.sel)
        0: begin
          ax = int'(x0); ay = int'(y0); ahit = int'(hit0); amiss = int'(miss0);
          ascore = int'(sc0); alives = int'(lv0); ago = int'(go0);
        end
        1: begin
          ax = int'(x1); ay = int'(y1); ahit = int'(hit1); amiss = int'(miss1);
          ascore = int'(sc1); alives = int'(lv1); ago = int'(go1);
        end
        default: begin
          ax = int'(x2); ay = int'(y2); ahit = int'(hit2); amiss = int'(miss2);
          ascore = int'(sc2); alives = int'(lv2); ago = int'(go2);
        end
      endcase
      if (m_e.chk_pos != 0) begin
        cmp("ball_x", m_e.step, ax, m_e.x);
        cmp("ball_y", m_e.step, ay, m_e.y);
      end
      cmp("hit", m_e.step, ahit, m_e.hit);
      cmp("miss", m_e.step, amiss, m_e.miss);
      cmp("score", m_e.step, ascore, m_e.score);
      cmp("lives", m_e.step, alives, m_e.lives);
      cmp("game_over", m_e.step, ago, m_e.go);
    end
  end

  // Ball path from SERVE entry with dx=dy=+1, start column 1
  int pa_x[10] = '{1, 1, 2, 3, 2, 1, 0, 1, 2, 3};
  int pa_y[10] = '{0, 0, 1, 2, 3, 4, 5, 6, 5, 4};

  initial begin
    int k, rnd, ex_x, ex_y, ex_miss, ex_lives, ex_go, l, r, h, nhits, sc;

    // Reset state and idle parking
    repeat (2) drive(1, 0, 1, 2, mk(0, 1, 1, 0, 0, 0, 0, 3, 0));
    drive(0, 0, 1, 2, mk(0, 1, 1, 0, 0, 0, 0, 3, 0));

    // Serve, wall bounce at col 3, wall bounce at col 0, paddle 1..2 hit
    for (int i = 0; i < 10; i++) begin
      drive(0, 1, 1, 2, mk(0, 1, pa_x[i], pa_y[i], (i == 8) ? 1 : 0, 0,
                           (i >= 8) ? 1 : 0, 3, 0));
    end
    // en low parks the ball; score and lives held
    repeat (2) drive(0, 0, 1, 2, mk(0, 1, 1, 0, 0, 0, 1, 3, 0));

    // Three misses (paddle 0..0, then inverted span 2..1) down to game over
    for (int e = 1; e <= 31; e++) begin
      k   = ((e - 1) % 10) + 1;
      rnd = (e - 1) / 10;
      l   = (e <= 10) ? 0 : 2;
      r   = (e <= 10) ? 0 : 1;
      ex_go = 0;
      if (e == 31) begin
        ex_x = 2; ex_y = 7; ex_miss = 0; ex_lives = 0; ex_go = 1;
      end else begin
        if (k <= 8) begin
          ex_x = pa_x[k - 1]; ex_y = pa_y[k - 1];
        end else begin
          ex_x = 2; ex_y = 7;
        end
        ex_miss  = (k == 9) ? 1 : 0;
        ex_lives = 3 - rnd - ((k >= 9) ? 1 : 0);
      end
      drive(0, 1, l, r, mk(0, 1, ex_x, ex_y, 0, ex_miss, 1, ex_lives, ex_go));
    end
    // en toggling has no effect once over
    for (int e = 0; e < 4; e++) begin
      drive(0, e % 2, 0, 0, mk(0, 1, 2, 7, 0, 0, 1, 0, 1));
    end
    // rst restores lives and score
    drive(1, 0, 1, 2, mk(0, 1, 1, 0, 0, 0, 0, 3, 0));
    drive(0, 0, 1, 2, mk(0, 1, 1, 0, 0, 0, 0, 3, 0));

    // TICK_DIV = 4: moves every 4 clks; en dropped on a tick cycle parks the ball
    for (int e = 1; e <= 18; e++) begin
      if (e <= 8)       begin ex_x = 1; ex_y = 0; end
      else if (e <= 12) begin ex_x = 2; ex_y = 1; end
      else if (e <= 16) begin ex_x = 3; ex_y = 2; end
      else              begin ex_x = 1; ex_y = 0; end
      drive(0, (e <= 16) ? 1 : 0, 1, 2, mk(1, 1, ex_x, ex_y, 0, 0, 0, 3, 0));
    end

    // SCORE_BITS = 2: full-width paddle, hits every 12 ticks, score saturates at 3
    drive(1, 0, 0, 3, mk(2, 1, 1, 0, 0, 0, 0, 3, 0));
    nhits = 0;
    for (int e = 1; e <= 46; e++) begin
      h = ((e >= 9) && (((e - 9) % 12) == 0)) ? 1 : 0;
      nhits += h;
      sc = (nhits > 3) ? 3 : nhits;
      drive(0, 1, 0, 3, mk(2, h, 2, 5, h, 0, sc, 3, 0));
    end

    repeat (2) @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
